// File: rtl/bram_rmw_initiator.sv
// Client-to-BRAM initiator: word reads, and byte-strobed writes done as read-modify-write.
// Optional FULL_WRITE_BYPASS_EN: all-ones strobes write directly, skipping the read.
module bram_rmw_initiator #(
   parameter int ADDRESS_BITWIDTH = 16,
   parameter int DATA_BITWIDTH    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ADDRESS_BITWIDTH-1:0]   req_address,
   input  logic [DATA_BITWIDTH/8-1:0]    req_wstrb,
   input  logic [DATA_BITWIDTH-1:0]      req_wdata,
   output logic                          rsp_valid,
   output logic [DATA_BITWIDTH-1:0]      rsp_data,
   output logic [ADDRESS_BITWIDTH-1:0]   bram_address,
   output logic                          bram_write_enable,
   output logic [DATA_BITWIDTH-1:0]      bram_data_in,
   input  logic [DATA_BITWIDTH-1:0]      bram_data_out
);

   localparam int STRB = DATA_BITWIDTH / 8;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

   state_t                        state, state_next;
   logic [ADDRESS_BITWIDTH-1:0]   addr_q;
   logic [STRB-1:0]               strb_q;
   logic [DATA_BITWIDTH-1:0]      wdata_q;
   logic [DATA_BITWIDTH-1:0]      merge;
   logic                          is_write;

   assign is_write     = |strb_q;
   assign bram_address = addr_q;

`ifdef FULL_WRITE_BYPASS_EN
   logic is_full;
   assign is_full = &strb_q;
`endif

   // With all strobes clear the merge is just the BRAM word, so reads reuse it.
   always_comb begin
      merge = '0;
      for (int i = 0; i < STRB; i++) begin
         merge[8*i +: 8] = strb_q[i] ? wdata_q[8*i +: 8] : bram_data_out[8*i +: 8];
      end
   end

   always_comb begin
      state_next        = state;
      req_ready         = 1'b0;
      bram_write_enable = 1'b0;
      bram_data_in      = merge;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = ISSUE;
         end
         ISSUE: begin
`ifdef FULL_WRITE_BYPASS_EN
            if (is_full) begin
               bram_write_enable = 1'b1;
               bram_data_in      = wdata_q;
               state_next        = IDLE;
            end else begin
               state_next = CAPTURE;
            end
`else
            state_next = CAPTURE;
`endif
         end
         CAPTURE: begin
            bram_write_enable = is_write;
            state_next        = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         strb_q    <= '0;
         wdata_q   <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         if (state == IDLE && req_valid) begin
            addr_q  <= req_address;
            strb_q  <= req_wstrb;
            wdata_q <= req_wdata;
         end
         if (state == CAPTURE) begin
            rsp_valid <= 1'b1;
            rsp_data  <= merge;
         end
`ifdef FULL_WRITE_BYPASS_EN
         if (state == ISSUE && is_full) begin
            rsp_valid <= 1'b1;
            rsp_data  <= wdata_q;
         end
`endif
      end
   end

endmodule

// File: tb/tb_bram_rmw_initiator.sv
// Scoreboarded bench for bram_rmw_initiator against a 16-word single-port BRAM model.
module tb_bram_rmw_initiator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_address = '0;
   logic [3:0]  req_wstrb = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic [3:0]  bram_address;
   logic        bram_write_enable;
   logic [31:0] bram_data_in;
   logic [31:0] bram_data_out;

   bram_rmw_initiator #(.ADDRESS_BITWIDTH(4), .DATA_BITWIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_address(req_address), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .bram_address(bram_address), .bram_write_enable(bram_write_enable),
      .bram_data_in(bram_data_in), .bram_data_out(bram_data_out)
   );

   always #5 clk = ~clk;

`ifdef FULL_WRITE_BYPASS_EN
   localparam int FULL_LAT = 2;
`else
   localparam int FULL_LAT = 3;
`endif

   // Single-port BRAM model, read-first, 1-cycle read latency, plus a preload port.
   logic [31:0] mem [16];
   logic        pl_en = 1'b0;
   logic [3:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;
   int          we_cnt = 0;
   int          cyc = 0;

   always @(posedge clk) begin
      if (bram_write_enable) mem[bram_address] <= bram_data_in;
      else if (pl_en)        mem[pl_addr] <= pl_data;
      bram_data_out <= mem[bram_address];
      we_cnt <= we_cnt + (bram_write_enable ? 1 : 0);
      cyc <= cyc + 1;
   end

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: every response must match the oldest expectation, in data and cycle.
   always @(negedge clk) begin
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data %h with no request outstanding", rsp_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_cycle", cyc, e.due);
         end
      end
   end

   task automatic preload(input logic [3:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // Present a request (req_valid left high) and wait for acceptance.
   task automatic send(input logic [3:0] a, input logic [3:0] s, input logic [31:0] d,
                       input logic [31:0] exp_d, input int lat, input bit expect_rsp,
                       output int acc);
      int k;
      exp_t e;
      req_valid = 1'b1; req_address = a; req_wstrb = s; req_wdata = d;
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
      acc = cyc;
      if (expect_rsp) begin
         e.data = exp_d;
         e.due  = cyc + lat;
         exp_q.push_back(e);
      end
      @(negedge clk);
      check("ready_low_busy", {31'd0, req_ready}, 32'd0);
   endtask

   task automatic drain();
      int k;
      req_valid = 1'b0;
      k = 0;
      while (exp_q.size() != 0 && k < 30) begin
         @(negedge clk);
         k++;
      end
      if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
      @(negedge clk);
   endtask

   logic [3:0]  v_addr [7] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0, 4'd0};
   logic [3:0]  v_strb [7] = '{4'h0, 4'hC, 4'h0, 4'hF, 4'h0, 4'h1, 4'h0};
   logic [31:0] v_wdat [7] = '{32'h0, 32'h12345678, 32'h0, 32'h55667788,
                               32'h0, 32'hFFFFFF99, 32'h0};
   logic [31:0] v_exp  [7] = '{32'hA0A0A0A0, 32'h1234B1B1, 32'h1234B1B1, 32'h55667788,
                               32'hDEADBEEF, 32'hA0A0A099, 32'hA0A0A099};

   initial begin
      int acc, prev, prev_lat, lat;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_we", {31'd0, bram_write_enable}, 32'd0);
      check("rst_addr", {28'd0, bram_address}, 32'd0);

      preload(4'd0, 32'hA0A0A0A0);
      preload(4'd1, 32'hB1B1B1B1);
      preload(4'd2, 32'hC2C2C2C2);
      preload(4'd3, 32'hDEADBEEF);
      preload(4'd5, 32'h11223344);
      preload(4'd7, 32'h00000000);
      preload(4'd9, 32'h0F0F0F0F);

      // Plain read
      send(4'd3, 4'h0, 32'h0, 32'hDEADBEEF, 3, 1'b1, acc);
      drain();
      check("t1_no_write", we_cnt, 32'd0);

      // Partial write merges with existing word
      send(4'd5, 4'h5, 32'hAABBCCDD, 32'h11BB33DD, 3, 1'b1, acc);
      drain();
      check("t2_mem5", mem[5], 32'h11BB33DD);

      // Full-strobe write, then readback
      send(4'd7, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D, FULL_LAT, 1'b1, acc);
      drain();
      check("t3_mem7", mem[7], 32'hCAFEF00D);
      send(4'd7, 4'h0, 32'h0, 32'hCAFEF00D, 3, 1'b1, acc);
      drain();
      check("t3_we_cnt", we_cnt, 32'd2);

      // Back-to-back with req_valid held: accept spacing equals previous latency
      prev = 0;
      prev_lat = 0;
      for (int i = 0; i < 7; i++) begin
         lat = (v_strb[i] == 4'hF) ? FULL_LAT : 3;
         send(v_addr[i], v_strb[i], v_wdat[i], v_exp[i], lat, 1'b1, acc);
         if (i > 0) check("t4_accept_gap", acc - prev, prev_lat);
         prev = acc;
         prev_lat = lat;
      end
      drain();
      check("t4_we_cnt", we_cnt, 32'd5);
      check("t4_mem1", mem[1], 32'h1234B1B1);

      // Reset during CAPTURE of a partial write
      send(4'd9, 4'h3, 32'h12345678, 32'h0, 3, 1'b0, acc);
      req_valid = 1'b0;
      @(negedge clk);
      check("t5_we_before_rst", {31'd0, bram_write_enable}, 32'd1);
      rst = 1'b1;
      #1;
      check("t5_we_at_rst", {31'd0, bram_write_enable}, 32'd0);
      check("t5_rsp_at_rst", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_mem9", mem[9], 32'h0F0F0F0F);
      check("t5_we_cnt", we_cnt, 32'd5);
      send(4'd9, 4'h0, 32'h0, 32'h0F0F0F0F, 3, 1'b1, acc);
      drain();

      // Zero strobes behave as a read
      send(4'd2, 4'h0, 32'hFFFFFFFF, 32'h55667788, 3, 1'b1, acc);
      drain();
      check("t6_mem2", mem[2], 32'h55667788);
      check("t6_we_cnt", we_cnt, 32'd5);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
